// File: rtl/ppf_commutator_ctrl.sv
// Input scheduler for an 8-branch direct-form polyphase filter bank.
// Accepts samples on an AXI4-Stream slave and writes them into the branch memories,
// highest branch first. After each complete block it pulses block_start_o, then holds
// off the stream until the filter core reports idle.
module ppf_commutator_ctrl #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [TDATA_WIDTH-1:0] S_TDATA,
  input  logic                   S_TVALID,
  input  logic                   S_TLAST,
  output logic                   S_TREADY,
  output logic [TDATA_WIDTH-1:0] branch_data_o,
  output logic [NUM_CH-1:0]      branch_we_o,
  output logic                   block_start_o,
  input  logic                   filt_busy_i,
  output logic [CNT_WIDTH-1:0]   block_cnt_o,
  output logic                   frame_err_o
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] WeLsb = NUM_CH'(1);

  typedef enum logic [1:0] {StFill, StIssue, StWait} state_e;

  state_e                 state_q, state_d;
  logic [ChW-1:0]         cnt_q, cnt_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_CH-1:0]      we_q, we_d;
  logic                   start_q, start_d;
  logic [CNT_WIDTH-1:0]   blk_q, blk_d;
  logic                   err_q, err_d;
  // Keeps S_TREADY low while reset is asserted even though the state resets to StFill.
  logic                   run_q;
  logic                   hs;

  // Ready is a pure register decode so it never loops back through S_TVALID.
  assign S_TREADY = run_q & (state_q == StFill);
  assign hs       = S_TVALID & S_TREADY;

  // Next-state and registered-output logic for the fill/issue/wait sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    we_d    = '0;
    start_d = 1'b0;
    blk_d   = blk_q;
    err_d   = err_q;
    unique case (state_q)
      StFill: begin
        if (hs) begin
          data_d = S_TDATA;
          // First sample of a block lands in the top branch, last one in branch 0.
          we_d   = WeLsb << (LastCh - cnt_q);
          if (cnt_q == LastCh) begin
            cnt_d   = '0;
            start_d = 1'b1;
            blk_d   = blk_q + CNT_WIDTH'(1);
            state_d = StIssue;
          end else if (S_TLAST) begin
            // Misaligned frame end: drop the partial block and restart at the top branch.
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ChW'(1);
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (!filt_busy_i) begin
          state_d = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StFill;
      cnt_q   <= '0;
      data_q  <= '0;
      we_q    <= '0;
      start_q <= 1'b0;
      blk_q   <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      we_q    <= we_d;
      start_q <= start_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  assign branch_data_o = data_q;
  assign branch_we_o   = we_q;
  assign block_start_o = start_q;
  assign block_cnt_o   = blk_q;
  assign frame_err_o   = err_q;

endmodule

// File: tb/tb_ppf_commutator_ctrl.sv
// Directed bench for ppf_commutator_ctrl: vector table for the basic block/TLAST flow,
// hand sequences for reset, back-pressure, a long scoreboarded stream and counter wrap.
module tb_ppf_commutator_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, filt_busy;

  logic        rdy, rdy4;
  logic [31:0] bdata, bdata4;
  logic [7:0]  we, we4;
  logic        start, start4, err, err4;
  logic [15:0] blk;
  logic [3:0]  blk4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppf_commutator_ctrl #(.TDATA_WIDTH(32), .NUM_CH(8), .CNT_WIDTH(16)) dut (
    .ACLK(clk), .ARESETn(rst_n), .S_TDATA(s_tdata), .S_TVALID(s_tvalid), .S_TLAST(s_tlast),
    .S_TREADY(rdy), .branch_data_o(bdata), .branch_we_o(we), .block_start_o(start),
    .filt_busy_i(filt_busy), .block_cnt_o(blk), .frame_err_o(err)
  );

  ppf_commutator_ctrl #(.TDATA_WIDTH(32), .NUM_CH(8), .CNT_WIDTH(4)) dut4 (
    .ACLK(clk), .ARESETn(rst_n), .S_TDATA(s_tdata), .S_TVALID(s_tvalid), .S_TLAST(s_tlast),
    .S_TREADY(rdy4), .branch_data_o(bdata4), .branch_we_o(we4), .block_start_o(start4),
    .filt_busy_i(filt_busy), .block_cnt_o(blk4), .frame_err_o(err4)
  );

  typedef struct {
    logic        v, l, b;
    logic [31:0] din;
    logic        rdy;
    logic [7:0]  we;
    logic [31:0] dout;
    logic        st, err;
    logic [15:0] blk;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic l, input logic b, input logic [31:0] din,
                     input logic r, input logic [7:0] w, input logic [31:0] dout,
                     input logic st, input logic e, input logic [15:0] bc);
    vec_t x;
    x.v = v; x.l = l; x.b = b; x.din = din; x.rdy = r; x.we = w; x.dout = dout;
    x.st = st; x.err = e; x.blk = bc;
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    filt_busy = 1'b0;
    step();
  endtask

  logic [31:0] smp[136];
  int          idx, nblk, busy_left;
  logic        hs, hs_prev;

  initial begin
    rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; filt_busy = 1'b0;
    for (int i = 0; i < 136; i++) smp[i] = i * 32'h9E3779B9 + 32'h1234;

    // v l b din rdy we dout st err blk
    add(1, 0, 0, 1, 1, 8'h80, 1, 0, 0, 0);
    add(1, 0, 0, 2, 1, 8'h40, 2, 0, 0, 0);
    add(1, 0, 0, 3, 1, 8'h20, 3, 0, 0, 0);
    add(1, 0, 0, 4, 1, 8'h10, 4, 0, 0, 0);
    add(1, 0, 0, 5, 1, 8'h08, 5, 0, 0, 0);
    add(1, 0, 0, 6, 1, 8'h04, 6, 0, 0, 0);
    add(1, 0, 0, 7, 1, 8'h02, 7, 0, 0, 0);
    add(1, 1, 0, 8, 1, 8'h01, 8, 1, 0, 1);   // aligned TLAST completes the block
    add(0, 0, 1, 0, 0, 8'h00, 8, 0, 0, 1);   // issue cycle; busy here is ignored
    add(0, 0, 0, 0, 0, 8'h00, 8, 0, 0, 1);   // wait cycle, core idle
    add(1, 0, 0, 1, 1, 8'h80, 1, 0, 0, 1);
    add(1, 0, 0, 2, 1, 8'h40, 2, 0, 0, 1);
    add(1, 0, 0, 3, 1, 8'h20, 3, 0, 0, 1);
    add(1, 0, 0, 4, 1, 8'h10, 4, 0, 0, 1);
    add(1, 1, 0, 5, 1, 8'h08, 5, 0, 1, 1);   // misaligned TLAST on 5th sample
    add(0, 0, 0, 0, 1, 8'h00, 5, 0, 1, 1);   // idle gap, count holds
    add(1, 0, 0, 6, 1, 8'h80, 6, 0, 1, 1);
    add(1, 0, 1, 7, 1, 8'h40, 7, 0, 1, 1);   // busy in fill is ignored
    add(1, 0, 0, 8, 1, 8'h20, 8, 0, 1, 1);

    // Reset values
    #2;
    chk("rst_ready", rdy, 0);
    chk("rst_we", we, 0);
    chk("rst_data", bdata, 0);
    chk("rst_start", start, 0);
    chk("rst_blk", blk, 0);
    chk("rst_err", err, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ready_after_release", rdy, 1);

    foreach (vecs[i]) begin
      s_tvalid = vecs[i].v; s_tlast = vecs[i].l; filt_busy = vecs[i].b; s_tdata = vecs[i].din;
      chk($sformatf("v%0d_ready", i), rdy, vecs[i].rdy);
      step();
      chk($sformatf("v%0d_we", i), we, vecs[i].we);
      chk($sformatf("v%0d_data", i), bdata, vecs[i].dout);
      chk($sformatf("v%0d_start", i), start, vecs[i].st);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_blk", i), blk, vecs[i].blk);
      chk($sformatf("v%0d_blk4", i), blk4, vecs[i].blk);
    end

    // Asynchronous reset after the 3rd sample of a block, pending write still visible
    s_tvalid = 1'b0; s_tlast = 1'b0; filt_busy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_ready", rdy, 0);
    chk("arst_data", bdata, 0);
    chk("arst_err", err, 0);
    chk("arst_blk", blk, 0);
    chk("arst_start", start, 0);
    step();
    rst_n = 1'b1;
    s_tvalid = 1'b1; s_tdata = 32'h11;
    chk("arst_ready_held", rdy, 0);
    step();
    chk("arst_no_early_write", we, 0);
    chk("arst_ready_up", rdy, 1);
    step();
    chk("arst_first_branch", we, 8'h80);
    chk("arst_first_data", bdata, 32'h11);
    chk("arst_blk_after", blk, 0);

    // Back-pressure while the core is busy for 20 cycles
    for (int k = 0; k < 7; k++) begin
      s_tdata = 32'h12 + k;
      step();
      chk($sformatf("bp_we%0d", k), we, 8'h80 >> (k + 1));
    end
    chk("bp_start", start, 1);
    chk("bp_blk", blk, 1);
    s_tdata = 32'h19;                         // 9th sample, held by the source
    step();
    chk("bp_start_one_cycle", start, 0);
    filt_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("bp_ready_busy%0d", k), rdy, 0);
      step();
      chk($sformatf("bp_we_busy%0d", k), we, 0);
    end
    filt_busy = 1'b0;
    chk("bp_ready_fall_cycle", rdy, 0);
    step();
    chk("bp_we_fall_cycle", we, 0);
    chk("bp_ready_back", rdy, 1);
    step();
    chk("bp_held_branch", we, 8'h80);
    chk("bp_held_data", bdata, 32'h19);

    // Long stream with random gaps and core latency, 17 blocks (16-bit count and 4-bit wrap)
    do_reset();
    idx = 0; nblk = 0; busy_left = 0; hs_prev = 1'b0;
    for (int cyc = 0; cyc < 3000 && idx < 136; cyc++) begin
      if (!s_tvalid || hs_prev) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = smp[idx];
        s_tlast  = (idx % 8 == 7);
      end
      chk("stream_ready_pair", rdy4, rdy);
      hs = s_tvalid & rdy;
      step();
      if (hs) begin
        chk("stream_we", we, 8'h80 >> (idx % 8));
        chk("stream_we4", we4, 8'h80 >> (idx % 8));
        chk("stream_data", bdata, smp[idx]);
        chk("stream_data4", bdata4, smp[idx]);
        chk("stream_start", start, (idx % 8 == 7));
        chk("stream_start4", start4, (idx % 8 == 7));
        if (idx % 8 == 7) begin
          nblk++;
          chk("stream_blk", blk, nblk);
          chk("stream_blk4", blk4, nblk % 16);
          busy_left = $urandom_range(0, 4);
        end
        idx++;
      end else begin
        chk("stream_we_idle", we, 0);
        chk("stream_start_idle", start, 0);
      end
      filt_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      hs_prev = hs;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    chk("stream_all_sent", idx, 136);
    chk("stream_nblk", nblk, 17);
    chk("stream_blk_final", blk, 17);
    chk("wrap_blk4_final", blk4, 1);
    chk("stream_err", err, 0);
    chk("stream_err4", err4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
